// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback request record.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_ld_fifo.sv
// In-order load-return buffer: each entry carries {rd, data, kill}.
// Killed entries still occupy a slot until popped, but drop out of pend_mask.
module wb_ld_fifo #(
  parameter int unsigned N     = 32,
  parameter int unsigned M     = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [M-1:0]             push_rd_i,
  input  logic [N-1:0]             push_data_i,
  input  logic                     pop_i,
  input  logic                     kill_en_i,
  input  logic [M-1:0]             kill_rd_i,
  output logic [M-1:0]             head_rd_o,
  output logic [N-1:0]             head_data_o,
  output logic                     head_kill_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [2**M-1:0]          pend_mask_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NR = 2**M;

  logic [M-1:0]  rd_q   [DEPTH];
  logic [M-1:0]  rd_d   [DEPTH];
  logic [N-1:0]  data_q [DEPTH];
  logic [N-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [DEPTH-1:0] occ;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off    = PW'(i) - rd_ptr_q;
      occ[i] = ({1'b0, off} < count_q);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    kill_d   = kill_q;
    rd_d     = rd_q;
    data_d   = data_q;
    if (kill_en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && (rd_q[i] == kill_rd_i)) kill_d[i] = 1'b1;
      end
    end
    if (pop_i) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_i) begin
      rd_d[wr_ptr_q]   = push_rd_i;
      data_d[wr_ptr_q] = push_data_i;
      kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      kill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      kill_q   <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && !kill_q[i]) pend_mask_o = pend_mask_o | (NR'(1) << rd_q[i]);
    end
    pend_mask_o[0] = 1'b0;
  end

  assign head_rd_o   = rd_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_kill_o = kill_q[rd_ptr_q];
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: ALU results win, loads queue behind them
// in order, and an ALU write kills any older queued load to the same register.
module wb_write_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned N     = XLEN,
  parameter int unsigned M     = REG_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [M-1:0]           alu_rd,
  input  logic [N-1:0]           alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [M-1:0]           ld_rd,
  input  logic [N-1:0]           ld_data,
  output logic                   RegWE,
  output logic [M-1:0]           adrs_w,
  output logic [N-1:0]           data_w,
  output logic [2**M-1:0]        pend_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);

  wb_req_t req_q, req_d;

  logic         alu_req, ld_live;
  logic         push, pop, kill_en;
  logic         full, empty;
  logic [M-1:0] head_rd;
  logic [N-1:0] head_data;
  logic         head_kill;

  assign ld_ready = !full;
  assign alu_req  = alu_valid && (alu_rd != '0);
  // Accepted loads to x0 are consumed here and never reach the queue.
  assign ld_live  = ld_valid && ld_ready && (ld_rd != '0);

  always_comb begin
    req_d       = req_q;
    req_d.valid = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    kill_en     = 1'b0;
    if (alu_req) begin
      req_d   = '{valid: 1'b1, rd: alu_rd, data: alu_data};
      kill_en = 1'b1;
      push    = ld_live && (ld_rd != alu_rd);
    end else if (!empty) begin
      pop  = 1'b1;
      push = ld_live;
      if (!head_kill) req_d = '{valid: 1'b1, rd: head_rd, data: head_data};
    end else if (ld_live) begin
      req_d = '{valid: 1'b1, rd: ld_rd, data: ld_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req_d;
  end

  assign RegWE  = req_q.valid;
  assign adrs_w = req_q.rd;
  assign data_w = req_q.data;

  wb_ld_fifo #(
    .N     (N),
    .M     (M),
    .DEPTH (DEPTH)
  ) u_ld_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .pop_i       (pop),
    .kill_en_i   (kill_en),
    .kill_rd_i   (alu_rd),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .head_kill_o (head_kill),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_count),
    .pend_mask_o (pend_mask)
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter; inputs change 1 time unit after each
// rising edge, outputs are checked at that same point.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        RegWE;
  logic [4:0]  adrs_w;
  logic [31:0] data_w;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  wb_write_arbiter #(
    .N     (32),
    .M     (5),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .RegWE      (RegWE),
    .adrs_w     (adrs_w),
    .data_w     (data_w),
    .pend_mask  (pend_mask),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = lr;
    ld_data   = ldd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL reset_we got %0b want 0", RegWE); else pass_cnt++;
    total_cnt++; if (adrs_w !== 5'd0) $display("FAIL reset_adrs got %0d want 0", adrs_w); else pass_cnt++;
    total_cnt++; if (data_w !== 32'h0) $display("FAIL reset_data got %h want 0", data_w); else pass_cnt++;
    total_cnt++; if (pend_mask !== 32'h0) $display("FAIL reset_pend got %h want 0", pend_mask); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", ld_ready); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL idle_we got %0b want 0", RegWE); else pass_cnt++;
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    step();
    total_cnt++; if (RegWE !== 1'b1) $display("FAIL alu_we got %0b want 1", RegWE); else pass_cnt++;
    total_cnt++; if (adrs_w !== 5'd5) $display("FAIL alu_adrs got %0d want 5", adrs_w); else pass_cnt++;
    total_cnt++; if (data_w !== 32'hDEADBEEF) $display("FAIL alu_data got %h want deadbeef", data_w); else pass_cnt++;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL alu_one_cycle got %0b want 0", RegWE); else pass_cnt++;
    total_cnt++; if (adrs_w !== 5'd5) $display("FAIL alu_hold_adrs got %0d want 5", adrs_w); else pass_cnt++;
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL alu_x0_we got %0b want 0", RegWE); else pass_cnt++;
    total_cnt++; if (data_w !== 32'hDEADBEEF) $display("FAIL alu_x0_hold got %h want deadbeef", data_w); else pass_cnt++;
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
    step();
    total_cnt++; if (RegWE !== 1'b1) $display("FAIL byp_we got %0b want 1", RegWE); else pass_cnt++;
    total_cnt++; if (adrs_w !== 5'd7) $display("FAIL byp_adrs got %0d want 7", adrs_w); else pass_cnt++;
    total_cnt++; if (data_w !== 32'h12) $display("FAIL byp_data got %h want 12", data_w); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL byp_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (pend_mask !== 32'h0) $display("FAIL byp_pend got %h want 0", pend_mask); else pass_cnt++;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL ld_x0_we got %0b want 0", RegWE); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL ld_x0_count got %0d want 0", fifo_count); else pass_cnt++;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
  endtask

  task automatic test_contention();
    logic        exp_we   [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0]  exp_rd   [12] = '{1, 2, 3, 4, 5, 6, 10, 11, 12, 13, 14, 14};
    logic [31:0] exp_dat  [12] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105,
                                   32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hE0, 32'hE0};
    logic [2:0]  exp_cnt  [12] = '{1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 0, 0};
    logic        exp_rdy  [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [31:0] exp_pend [12] = '{32'h0400, 32'h0C00, 32'h1C00, 32'h3C00, 32'h3C00, 32'h3C00,
                                   32'h3800, 32'h7000, 32'h6000, 32'h4000, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      drive(i < 6, 5'(i + 1), 32'h100 + 32'(i),
            i <= 7, (i < 4) ? 5'(10 + i) : 5'd14, (i < 4) ? 32'hA0 + 32'(i) : 32'hE0);
      step();
      total_cnt++;
      if (RegWE !== exp_we[i] || (exp_we[i] &&
          (adrs_w !== exp_rd[i] || data_w !== exp_dat[i])))
        $display("FAIL cont_write[%0d] got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                 i, RegWE, adrs_w, data_w, exp_we[i], exp_rd[i], exp_dat[i]);
      else pass_cnt++;
      total_cnt++;
      if (fifo_count !== exp_cnt[i])
        $display("FAIL cont_count[%0d] got %0d want %0d", i, fifo_count, exp_cnt[i]);
      else pass_cnt++;
      total_cnt++;
      if (ld_ready !== exp_rdy[i])
        $display("FAIL cont_ready[%0d] got %0b want %0b", i, ld_ready, exp_rdy[i]);
      else pass_cnt++;
      total_cnt++;
      if (pend_mask !== exp_pend[i])
        $display("FAIL cont_pend[%0d] got %h want %h", i, pend_mask, exp_pend[i]);
      else pass_cnt++;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_waw();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h88);
    step();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'hAA);
    step();
    total_cnt++; if (pend_mask !== 32'h300) $display("FAIL waw_pend_before got %h want 300", pend_mask); else pass_cnt++;
    drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0);
    step();
    total_cnt++; if (RegWE !== 1'b1 || adrs_w !== 5'd9 || data_w !== 32'hBB)
      $display("FAIL waw_alu got we=%0b rd=%0d data=%h want we=1 rd=9 data=bb", RegWE, adrs_w, data_w);
    else pass_cnt++;
    total_cnt++; if (pend_mask !== 32'h100) $display("FAIL waw_pend_kill got %h want 100", pend_mask); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd2) $display("FAIL waw_count got %0d want 2", fifo_count); else pass_cnt++;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    total_cnt++; if (RegWE !== 1'b1 || adrs_w !== 5'd8 || data_w !== 32'h88)
      $display("FAIL waw_r8 got we=%0b rd=%0d data=%h want we=1 rd=8 data=88", RegWE, adrs_w, data_w);
    else pass_cnt++;
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL waw_killed_slot got we=%0b rd=%0d want we=0", RegWE, adrs_w); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL waw_drained got %0d want 0", fifo_count); else pass_cnt++;
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL waw_after got %0b want 0", RegWE); else pass_cnt++;
    drive(1'b1, 5'd9, 32'hCC, 1'b1, 5'd9, 32'hDD);
    step();
    total_cnt++; if (RegWE !== 1'b1 || adrs_w !== 5'd9 || data_w !== 32'hCC)
      $display("FAIL waw_same got we=%0b rd=%0d data=%h want we=1 rd=9 data=cc", RegWE, adrs_w, data_w);
    else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL waw_same_count got %0d want 0", fifo_count); else pass_cnt++;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL waw_same_drop got we=%0b data=%h want we=0", RegWE, data_w); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 1), 32'h10 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
      step();
    end
    total_cnt++; if (fifo_count !== 3'd3) $display("FAIL rmid_fill got %0d want 3", fifo_count); else pass_cnt++;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rmid_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (pend_mask !== 32'h0) $display("FAIL rmid_pend got %h want 0", pend_mask); else pass_cnt++;
    total_cnt++; if (RegWE !== 1'b0) $display("FAIL rmid_we got %0b want 0", RegWE); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (RegWE !== 1'b0) $display("FAIL rmid_ghost[%0d] got we=%0b rd=%0d want we=0", i, RegWE, adrs_w);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_alu();
    test_bypass();
    test_contention();
    test_waw();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
